// File: rtl/mac_sequencer.sv
// mac_sequencer: streams signed operand pairs into an external DSP MAC slice,
// drains its pipeline and returns the accumulated dot product through a
// valid/ready handshake.
module mac_sequencer #(
  parameter int LATENCY   = 3,   // enabled DSP cycles from dsp_a/dsp_b to dsp_p
  parameter int CTRL_SKEW = 1,   // enabled cycles opmode lags its operand beat (>= 1)
  parameter int LEN_W     = 16   // width of the job length
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                start_ready,
  input  logic [LEN_W-1:0]    len,
  input  logic signed [29:0]  in_a,
  input  logic signed [17:0]  in_b,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [29:0]         dsp_a,
  output logic [17:0]         dsp_b,
  output logic [26:0]         dsp_d,
  output logic [8:0]          dsp_opmode,
  output logic [4:0]          dsp_inmode,
  output logic [3:0]          dsp_alumode,
  output logic                dsp_enable,
  output logic                dsp_rst,
  input  logic signed [47:0]  dsp_p,
  output logic signed [47:0]  result,
  output logic                result_valid,
  input  logic                result_ready
);

  localparam logic [8:0] OP_LOAD = 9'b000000101;  // P = M
  localparam logic [8:0] OP_ACC  = 9'b000100101;  // P = P + M
  // Drain counter must be able to hold LATENCY itself.
  localparam int DW = $clog2(LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                    first_q, first_d;
  logic [29:0]             dsp_a_q, dsp_a_d;
  logic [17:0]             dsp_b_q, dsp_b_d;
  // Opmode belonging to the operands currently on dsp_a/dsp_b; it then
  // travels CTRL_SKEW enabled stages so it reaches the DSP aligned with them.
  logic [8:0]              op_cur_q, op_cur_d;
  logic signed [47:0]      result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  // Next-state logic, DSP enable and operand/opmode selection.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    first_d        = first_q;
    dsp_a_d        = dsp_a_q;
    dsp_b_d        = dsp_b_q;
    op_cur_d       = op_cur_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    dsp_enable     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d    = RUN;
            beat_cnt_d = len;
            first_d    = 1'b1;
          end else begin
            // Empty job: answer immediately without touching the DSP.
            state_d        = HOLD;
            result_d       = '0;
            result_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        // The DSP only advances on accepted beats, so stalls freeze it whole.
        dsp_enable = in_valid;
        if (in_valid) begin
          dsp_a_d    = in_a;
          dsp_b_d    = in_b;
          op_cur_d   = first_q ? OP_LOAD : OP_ACC;
          first_d    = 1'b0;
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q != DW'(LATENCY)) begin
          // Push zero products through so the last real beat reaches dsp_p.
          dsp_enable  = 1'b1;
          dsp_a_d     = '0;
          dsp_b_d     = '0;
          op_cur_d    = OP_ACC;
          drain_cnt_d = drain_cnt_q + DW'(1);
        end else begin
          // dsp_p now carries the complete sum; pipeline stays frozen.
          state_d        = HOLD;
          result_d       = dsp_p;
          result_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, DSP operand registers and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      first_q        <= 1'b0;
      dsp_a_q        <= '0;
      dsp_b_q        <= '0;
      op_cur_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      first_q        <= first_d;
      dsp_a_q        <= dsp_a_d;
      dsp_b_q        <= dsp_b_d;
      op_cur_q       <= op_cur_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Opmode skew line: each stage moves only when the DSP is enabled.
  for (genvar gi = 0; gi < CTRL_SKEW; gi++) begin : g_op
    logic [8:0] op_q;
    logic [8:0] stage_in;
    if (gi == 0) begin : g_head
      assign stage_in = op_cur_q;
    end else begin : g_tail
      assign stage_in = g_op[gi-1].op_q;
    end
    // One opmode delay stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        op_q <= '0;
      end else if (dsp_enable) begin
        op_q <= stage_in;
      end
    end
  end

  assign dsp_opmode   = g_op[CTRL_SKEW-1].op_q;
  assign start_ready  = (state_q == IDLE);
  assign in_ready     = (state_q == RUN);
  assign dsp_a        = dsp_a_q;
  assign dsp_b        = dsp_b_q;
  assign dsp_d        = '0;
  assign dsp_inmode   = 5'b00000;
  assign dsp_alumode  = 4'b0000;
  assign dsp_rst      = !rst_n;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives table-driven dot-product jobs into mac_sequencer
// with a behavioural DSP slice attached, and scoreboards returned results.
module tb_mac_sequencer;

  localparam int LATENCY   = 3;
  localparam int CTRL_SKEW = 1;
  localparam int LEN_W     = 16;
  localparam logic [8:0] OP_LOAD = 9'b000000101;
  localparam logic [8:0] OP_ACC  = 9'b000100101;

  logic               clk = 1'b0;
  logic               rst_n, start, start_ready, in_valid, in_ready;
  logic [LEN_W-1:0]   len;
  logic signed [29:0] in_a;
  logic signed [17:0] in_b;
  logic [29:0]        dsp_a;
  logic [17:0]        dsp_b;
  logic [26:0]        dsp_d;
  logic [8:0]         dsp_opmode;
  logic [4:0]         dsp_inmode;
  logic [3:0]         dsp_alumode;
  logic               dsp_enable, dsp_rst;
  logic signed [47:0] dsp_p;
  logic signed [47:0] result;
  logic               result_valid, result_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  logic signed [47:0] exp_q [$];

  mac_sequencer #(.LATENCY(LATENCY), .CTRL_SKEW(CTRL_SKEW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready), .len(len),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
    .dsp_inmode(dsp_inmode), .dsp_alumode(dsp_alumode), .dsp_enable(dsp_enable),
    .dsp_rst(dsp_rst), .dsp_p(dsp_p), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Behavioural DSP: product pipe of LATENCY-1 stages, opmode registered
  // on arrival, P updated on the LATENCY-th enabled edge.
  logic signed [47:0] m_pipe [LATENCY-1];
  logic [8:0]         o_pipe [LATENCY-1-CTRL_SKEW];
  always @(posedge clk) begin
    if (dsp_rst) begin
      for (int i = 0; i < LATENCY-1; i++) m_pipe[i] <= '0;
      for (int i = 0; i < LATENCY-1-CTRL_SKEW; i++) o_pipe[i] <= '0;
      dsp_p <= '0;
    end else if (dsp_enable) begin
      m_pipe[0] <= $signed({{18{dsp_a[29]}}, dsp_a}) * $signed({{30{dsp_b[17]}}, dsp_b});
      for (int i = 1; i < LATENCY-1; i++) m_pipe[i] <= m_pipe[i-1];
      o_pipe[0] <= dsp_opmode;
      for (int i = 1; i < LATENCY-1-CTRL_SKEW; i++) o_pipe[i] <= o_pipe[i-1];
      case (o_pipe[LATENCY-2-CTRL_SKEW])
        OP_ACC:  dsp_p <= dsp_p + m_pipe[LATENCY-2];
        OP_LOAD: dsp_p <= m_pipe[LATENCY-2];
        default: dsp_p <= '0;
      endcase
    end
  end

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard/monitor: latency, hold stability and result pop on handshake.
  initial begin : monitor
    int acc_edge = 0;
    int z_edge = 0;
    bit zlen = 0;
    bit prev_rv = 0;
    logic signed [47:0] held = '0;
    logic signed [47:0] want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rv = 0;
        zlen = 0;
      end else begin
        if (result_valid && !prev_rv) begin
          if (zlen) chk("zero_len_valid_edge", edge_n - z_edge, 0);
          else      chk("drain_latency", edge_n - acc_edge, LATENCY + 1);
          zlen = 0;
          held = result;
        end else if (result_valid) begin
          chk("hold_stable", result, held);
        end
        if (result_valid && result_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result_count", 1, 0);
          end else begin
            want = exp_q.pop_front();
            $display("result %0d expected %0d at edge %0d", result, want, edge_n + 1);
            chk("result", result, want);
          end
        end
        if (in_valid && in_ready) acc_edge = edge_n + 1;
        if (start && start_ready && len == '0) begin
          zlen = 1;
          z_edge = edge_n + 1;
        end
        prev_rv = result_valid;
      end
    end
  end

  typedef struct {
    int                 len;
    logic [3:0][29:0]   a;
    logic [3:0][17:0]   b;
    int                 gap;
    int                 hold;
    logic signed [47:0] exp;
  } job_t;
  job_t tbl [6];

  task automatic add_job(input int idx, input int l, input logic [3:0][29:0] a,
                         input logic [3:0][17:0] b, input int gap, input int hold,
                         input logic signed [47:0] e);
    tbl[idx].len = l; tbl[idx].a = a; tbl[idx].b = b;
    tbl[idx].gap = gap; tbl[idx].hold = hold; tbl[idx].exp = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(start_ready && exp_q.size() == 0) && w < 300) begin cyc(); w++; end
    chk("job_completes", (w < 300), 1);
    if (w >= 300) exp_q.delete();
  endtask

  task automatic run_job(input job_t j);
    int w;
    wait_idle();
    start = 1'b1; len = LEN_W'(j.len); result_ready = (j.hold == 0);
    exp_q.push_back(j.exp);
    cyc();
    start = 1'b0;
    if (j.len == 0) chk("zero_len_enable", dsp_enable, 0);
    for (int k = 0; k < j.len; k++) begin
      if (k > 0) begin
        for (int g = 0; g < j.gap; g++) begin
          in_valid = 1'b0;
          #1;
          chk("gap_enable", dsp_enable, 0);
          chk("gap_hold_a", dsp_a, j.a[k-1]);
          cyc();
        end
      end
      in_valid = 1'b1; in_a = j.a[k]; in_b = j.b[k];
      #1;
      chk("beat_ready", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    if (j.len > 0) begin
      #1;
      chk("drain_in_ready", in_ready, 0);
      chk("drain_enable", dsp_enable, 1);
      cyc();
      chk("drain_zero_a", dsp_a, 0);
    end
    if (j.hold > 0) begin
      w = 0;
      while (!result_valid && w < 100) begin cyc(); w++; end
      chk("valid_seen", result_valid, 1);
      for (int h = 0; h < j.hold; h++) begin
        // Stray start and operand traffic while holding must be ignored.
        start = 1'b1; len = LEN_W'(5); in_valid = 1'b1; in_a = 30'h155; in_b = 18'h2a;
        #1;
        chk("hold_start_ready", start_ready, 0);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_enable", dsp_enable, 0);
        cyc();
      end
      start = 1'b0; in_valid = 1'b0; result_ready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic reset_mid_run();
    wait_idle();
    start = 1'b1; len = LEN_W'(8);
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 30'(k + 5); in_b = 18'(k + 1);
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_dsp_rst", dsp_rst, 1);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_start_ready", start_ready, 1);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_enable", dsp_enable, 0);
    chk("mid_result_valid", result_valid, 0);
    chk("mid_result", result, 0);
    chk("mid_dsp_a", dsp_a, 0);
    chk("mid_dsp_b", dsp_b, 0);
    chk("mid_opmode", dsp_opmode, 0);
    in_valid = 1'b0;
  endtask

  task automatic long_job();
    longint pa, pb;
    logic signed [47:0] e;
    wait_idle();
    pa = (longint'(1) << 29) - 1;
    pb = (longint'(1) << 17) - 1;
    e = 48'(longint'(65535) * pa * pb);
    start = 1'b1; len = '1; result_ready = 1'b1;
    exp_q.push_back(e);
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_a = 30'h1FFFFFFF; in_b = 18'h1FFFF;
    for (int k = 0; k < 65535; k++) cyc();
    in_valid = 1'b0;
    #1;
    chk("long_drain_in_ready", in_ready, 0);
    wait_idle();
  endtask

  initial begin : watchdog
    #1500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; start = 1'b1; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; result_ready = 1'b1;
    add_job(0, 4, {30'd4, 30'd3, 30'd2, 30'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 0, 0, 48'sd70);
    add_job(1, 3, {30'd0, 30'd1, 30'd2, 30'(-100000)}, {18'd0, 18'(-1), 18'(-4), 18'd3},
            2, 0, -48'sd300009);
    add_job(2, 0, '0, '0, 0, 0, 48'sd0);
    add_job(3, 2, {30'd0, 30'd0, 30'd7, 30'd7}, {18'd0, 18'd0, 18'd1, 18'd1}, 0, 5, 48'sd14);
    add_job(4, 1, {30'd0, 30'd0, 30'd0, 30'd3}, {18'd0, 18'd0, 18'd0, 18'd3}, 0, 0, 48'sd9);
    add_job(5, 1, {30'd0, 30'd0, 30'd0, 30'd2}, {18'd0, 18'd0, 18'd0, 18'd2}, 0, 0, 48'sd4);

    repeat (3) cyc();
    chk("rst_dsp_rst", dsp_rst, 1);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_enable", dsp_enable, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_b", dsp_b, 0);
    chk("rst_opmode", dsp_opmode, 0);
    chk("const_dsp_d", dsp_d, 0);
    chk("const_inmode", dsp_inmode, 0);
    chk("const_alumode", dsp_alumode, 0);

    // start (len 0) held through reset: taken on the first edge out of it.
    exp_q.push_back(48'sd0);
    rst_n = 1'b1;
    cyc();
    chk("first_start_taken", start_ready, 0);
    chk("first_start_valid", result_valid, 1);
    chk("run_dsp_rst", dsp_rst, 0);
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_mid_run();
      $display("job %0d len=%0d gap=%0d hold=%0d", i, tbl[i].len, tbl[i].gap, tbl[i].hold);
      run_job(tbl[i]);
    end
    long_job();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
